// File: rtl/alu_pkg.sv
// Purpose : shared opcode encoding, flag bit positions and opcode class helper for the pipelined ALU.
// Latency : n/a (type and function definitions only).
// Backpr. : n/a.
package alu_pkg;

   typedef enum logic [3:0] {
      TFRA  = 4'd0,
      ADD   = 4'd1,
      SUB   = 4'd2,
      INCRA = 4'd3,
      DECRA = 4'd4,
      INCRB = 4'd5,
      DECRB = 4'd6,
      TFRB  = 4'd7,
      OR_G  = 4'd8,
      XOR_G = 4'd9,
      AND_G = 4'd10,
      NOT_G = 4'd11
   } opcode_e;

   // Bit positions inside the 4-bit {V,N,C,Z} flag vector.
   localparam int FLAG_Z = 0;
   localparam int FLAG_C = 1;
   localparam int FLAG_N = 2;
   localparam int FLAG_V = 3;

   // Encodings at or above this value are reported as illegal.
   localparam int NUM_OPS = 12;

   function automatic logic is_arith(opcode_e op);
      return (op == ADD)   || (op == SUB)   || (op == INCRA) ||
             (op == DECRA) || (op == INCRB) || (op == DECRB);
   endfunction

endpackage

// File: rtl/alu_pipe_exec.sv
// Purpose : combinational ALU datapath computing result, {V,N,C,Z} flags and illegal bit from stage-1 registers.
// Latency : 0 cycles (pure combinational).
// Backpr. : none; the enclosing pipeline decides when the outputs are captured.
// Ports   : a_i/b_i operands, op_i opcode; result_o (MSB = carry/borrow), flags_o {V,N,C,Z}, illegal_o.
// Build   : define ALU_SATURATE_EN to clamp arithmetic on carry/borrow instead of wrapping.
module alu_pipe_exec
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int OPCODE_WIDTH = 4
) (
   input  logic [DATA_WIDTH-1:0]   a_i,
   input  logic [DATA_WIDTH-1:0]   b_i,
   input  logic [OPCODE_WIDTH-1:0] op_i,
   output logic [DATA_WIDTH:0]     result_o,
   output logic [3:0]              flags_o,
   output logic                    illegal_o
);

   localparam int W = DATA_WIDTH;

   opcode_e      op;
   logic         arith;
   logic         sub_en;
   logic [W-1:0] x;
   logic [W-1:0] y;
   logic [W:0]   sum;
   logic         carry;
   logic         ovf;
   logic [W-1:0] lo;

   always_comb begin
      illegal_o = (op_i >= OPCODE_WIDTH'(NUM_OPS));
      // Illegal encodings behave exactly like a transfer of A.
      op        = illegal_o ? TFRA : opcode_e'(op_i[3:0]);
      arith     = is_arith(op);
      sub_en    = (op == SUB) || (op == DECRA) || (op == DECRB);

      // One shared adder: INC/DEC are ADD/SUB with a constant 1 as second operand.
      x   = ((op == INCRB) || (op == DECRB)) ? b_i : a_i;
      y   = ((op == ADD) || (op == SUB)) ? b_i : W'(1);
      // Zero-extended subtract leaves the borrow in the top bit.
      sum = sub_en ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});

      carry = arith & sum[W];
      ovf   = arith & (sub_en ? (x[W-1] != y[W-1]) : (x[W-1] == y[W-1]))
                    & (sum[W-1] != x[W-1]);

      case (op)
         ADD, SUB, INCRA, DECRA, INCRB, DECRB: lo = sum[W-1:0];
         TFRB:    lo = b_i;
         OR_G:    lo = a_i | b_i;
         XOR_G:   lo = a_i ^ b_i;
         AND_G:   lo = a_i & b_i;
         NOT_G:   lo = ~a_i;
         default: lo = a_i;
      endcase

`ifdef ALU_SATURATE_EN
      // Unsigned clamp; the carry/borrow bit and V still describe the raw operation.
      if (carry) begin
         lo = sub_en ? '0 : '1;
      end
`else
`endif

      result_o         = {carry, lo};
      flags_o          = '0;
      flags_o[FLAG_Z]  = (lo == '0);
      flags_o[FLAG_C]  = carry;
      flags_o[FLAG_N]  = lo[W-1];
      flags_o[FLAG_V]  = ovf;
   end

endmodule

// File: rtl/alu_pipe.sv
// Purpose : 2-stage valid/ready pipelined ALU (S1 = operand registers, S2 = result registers).
// Latency : a beat presented with in_valid&&in_ready in cycle k shows on the outputs in cycle k+2.
// Backpr. : out_ready=0 freezes S2 outputs; S1 holds and in_ready falls once S1 is occupied.
// Ports   : clk, rst (sync, active-high); in_valid/in_ready with a_in, b_in, opcode_in;
//           out_valid/out_ready with result_out (MSB = carry/borrow), flags_out {V,N,C,Z}, illegal_out.
// Build   : ALU_SATURATE_EN selects clamping arithmetic in alu_pipe_exec; ports and latency unchanged.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int OPCODE_WIDTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_WIDTH-1:0]   a_in,
   input  logic [DATA_WIDTH-1:0]   b_in,
   input  logic [OPCODE_WIDTH-1:0] opcode_in,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_WIDTH:0]     result_out,
   output logic [3:0]              flags_out,
   output logic                    illegal_out
);

   localparam int W = DATA_WIDTH;

   logic                    s1_vld_q, s1_vld_d;
   logic [W-1:0]            s1_a_q, s1_a_d;
   logic [W-1:0]            s1_b_q, s1_b_d;
   logic [OPCODE_WIDTH-1:0] s1_op_q, s1_op_d;

   logic                    s2_vld_q, s2_vld_d;
   logic [W:0]              s2_res_q, s2_res_d;
   logic [3:0]              s2_flags_q, s2_flags_d;
   logic                    s2_ill_q, s2_ill_d;

   logic                    s1_adv;
   logic                    s2_adv;

   logic [W:0]              exe_res;
   logic [3:0]              exe_flags;
   logic                    exe_ill;

   alu_pipe_exec #(
      .DATA_WIDTH   (DATA_WIDTH),
      .OPCODE_WIDTH (OPCODE_WIDTH)
   ) u_exec (
      .a_i       (s1_a_q),
      .b_i       (s1_b_q),
      .op_i      (s1_op_q),
      .result_o  (exe_res),
      .flags_o   (exe_flags),
      .illegal_o (exe_ill)
   );

   always_comb begin
      // S2 moves when empty or drained this cycle; S1 may then refill in the same cycle.
      s2_adv   = !s2_vld_q || out_ready;
      s1_adv   = !s1_vld_q || s2_adv;
      in_ready = s1_adv;

      s1_vld_d   = s1_vld_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_op_d    = s1_op_q;
      s2_vld_d   = s2_vld_q;
      s2_res_d   = s2_res_q;
      s2_flags_d = s2_flags_q;
      s2_ill_d   = s2_ill_q;

      if (s2_adv) begin
         s2_vld_d = s1_vld_q;
         if (s1_vld_q) begin
            s2_res_d   = exe_res;
            s2_flags_d = exe_flags;
            s2_ill_d   = exe_ill;
         end
      end

      if (s1_adv) begin
         s1_vld_d = in_valid;
         if (in_valid) begin
            s1_a_d  = a_in;
            s1_b_d  = b_in;
            s1_op_d = opcode_in;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld_q   <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_op_q    <= '0;
         s2_vld_q   <= 1'b0;
         s2_res_q   <= '0;
         s2_flags_q <= '0;
         s2_ill_q   <= 1'b0;
      end else begin
         s1_vld_q   <= s1_vld_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s1_op_q    <= s1_op_d;
         s2_vld_q   <= s2_vld_d;
         s2_res_q   <= s2_res_d;
         s2_flags_q <= s2_flags_d;
         s2_ill_q   <= s2_ill_d;
      end
   end

   assign out_valid   = s2_vld_q;
   assign result_out  = s2_res_q;
   assign flags_out   = s2_flags_q;
   assign illegal_out = s2_ill_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Purpose : self-checking bench for alu_pipe (DATA_WIDTH=8) with directed cases plus random traffic.
// Latency : checks the two-cycle result latency and in-order delivery against a reference queue.
// Backpr. : drives out_ready low in bursts and checks outputs stay frozen while stalled.
module tb_alu_pipe;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a_in;
   logic [7:0] b_in;
   logic [3:0] opcode_in;
   logic       out_valid;
   logic       out_ready;
   logic [8:0] result_out;
   logic [3:0] flags_out;
   logic       illegal_out;

   alu_pipe #(
      .DATA_WIDTH   (8),
      .OPCODE_WIDTH (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a_in        (a_in),
      .b_in        (b_in),
      .opcode_in   (opcode_in),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result_out  (result_out),
      .flags_out   (flags_out),
      .illegal_out (illegal_out)
   );

   always #5 clk = ~clk;

   int npass  = 0;
   int ntotal = 0;
   int n_out  = 0;

   // Expected beats in order: {illegal, V, N, C, Z, result[8:0]}.
   logic [13:0] exp_q[$];
   logic        hold_pend = 1'b0;
   logic [14:0] hold_val;
   logic        acc;
   logic        stall;

   // Reference: plain integer arithmetic on the opcode table.
   function automatic logic [13:0] ref_calc(int a, int b, int op);
      int  x, y, raw, lo, sx, sy, sr;
      bit  arith, sub, carry, v, ill;
      logic [8:0] res;
      arith = 1; sub = 0; carry = 0; v = 0; ill = 0; x = a; y = b; lo = 0;
      case (op)
         1:  begin x = a; y = b; end
         2:  begin x = a; y = b; sub = 1; end
         3:  begin x = a; y = 1; end
         4:  begin x = a; y = 1; sub = 1; end
         5:  begin x = b; y = 1; end
         6:  begin x = b; y = 1; sub = 1; end
         default: arith = 0;
      endcase
      if (arith) begin
         raw   = sub ? x - y : x + y;
         carry = sub ? (raw < 0) : (raw > 255);
         lo    = (raw + 256) % 256;
         sx    = (x >= 128) ? x - 256 : x;
         sy    = (y >= 128) ? y - 256 : y;
         sr    = sub ? sx - sy : sx + sy;
         v     = (sr > 127) || (sr < -128);
`ifdef ALU_SATURATE_EN
         if (carry) lo = sub ? 0 : 255;
`endif
      end else begin
         case (op)
            0:  lo = a;
            7:  lo = b;
            8:  lo = a | b;
            9:  lo = a ^ b;
            10: lo = a & b;
            11: lo = 255 - a;
            default: begin lo = a; ill = 1; end
         endcase
      end
      res = 9'(carry * 256 + lo);
      return {ill, v, (lo >= 128), carry, (lo == 0), res};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntotal++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // One clock: scoreboard handshakes at the falling edge, then return 1 time unit after the rising edge.
   task automatic tick();
      @(negedge clk);
      acc   = 1'b0;
      stall = in_valid && !in_ready;
      if (rst) begin
         exp_q.delete();
         hold_pend = 1'b0;
      end else begin
         if (hold_pend)
            chk("hold_stable", {out_valid, illegal_out, flags_out, result_out}, hold_val);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("sb_unexpected", exp_q.size(), 1);
            else chk("sb_data", {illegal_out, flags_out, result_out}, exp_q.pop_front());
            n_out++;
         end
         hold_pend = out_valid && !out_ready;
         hold_val  = {out_valid, illegal_out, flags_out, result_out};
         if (in_valid && in_ready) begin
            exp_q.push_back(ref_calc(a_in, b_in, opcode_in));
            acc = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic single(input string tag, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                         input logic [8:0] e_res, input logic [3:0] e_flg, input logic e_ill);
      a_in = a; b_in = b; opcode_in = op; in_valid = 1'b1; out_ready = 1'b1;
      chk({tag, "_in_ready"}, in_ready, 1);
      tick();
      in_valid = 1'b0;
      chk({tag, "_lat1_vld"}, out_valid, 0);
      tick();
      chk({tag, "_lat2_vld"}, out_valid, 1);
      chk({tag, "_res"}, result_out, e_res);
      chk({tag, "_flags"}, flags_out, e_flg);
      chk({tag, "_illegal"}, illegal_out, e_ill);
      tick();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int sent, base, saw_drop, cyc;
      logic pending;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a_in = '0; b_in = '0; opcode_in = '0;
      tick();
      tick();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", result_out, 0);
      chk("rst_flags", flags_out, 0);
      chk("rst_illegal", illegal_out, 0);
      rst = 1'b0;
      chk("rst_in_ready", in_ready, 1);

      // Directed cases; flags are {V,N,C,Z}.
`ifdef ALU_SATURATE_EN
      single("add_ff_01", 8'hFF, 8'h01, 4'd1, 9'h1FF, 4'b0110, 1'b0);
      single("sub_00_01", 8'h00, 8'h01, 4'd2, 9'h100, 4'b0011, 1'b0);
`else
      single("add_ff_01", 8'hFF, 8'h01, 4'd1, 9'h100, 4'b0011, 1'b0);
      single("sub_00_01", 8'h00, 8'h01, 4'd2, 9'h1FF, 4'b0110, 1'b0);
`endif
      single("sub_80_01", 8'h80, 8'h01, 4'd2, 9'h07F, 4'b1000, 1'b0);
      single("tfrb",      8'h12, 8'h34, 4'd7, 9'h034, 4'b0000, 1'b0);
      single("not_0f",    8'h0F, 8'h00, 4'd11, 9'h0F0, 4'b0100, 1'b0);
      single("illegal13", 8'h5A, 8'h00, 4'd13, 9'h05A, 4'b0000, 1'b1);

      // Ten back-to-back beats with a 4-cycle downstream stall.
      sent = 0; base = n_out; saw_drop = 0; pending = 1'b0;
      for (int c = 0; c < 60 && (sent < 10 || n_out - base < 10); c++) begin
         out_ready = !(c >= 3 && c <= 6);
         if (sent < 10) begin
            if (!pending) begin
               a_in = 8'($urandom); b_in = 8'($urandom); opcode_in = 4'($urandom_range(0, 11));
               pending = 1'b1;
            end
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         tick();
         if (stall) saw_drop = 1;
         if (acc) begin sent++; pending = 1'b0; end
      end
      in_valid = 1'b0;
      chk("b2b_sent", sent, 10);
      chk("b2b_received", n_out - base, 10);
      chk("b2b_queue_empty", exp_q.size(), 0);
      chk("b2b_in_ready_dropped", saw_drop, 1);

      // Random traffic with random backpressure.
      pending = 1'b0;
      for (int c = 0; c < 600; c++) begin
         if (!pending) begin
            in_valid  = 1'($urandom_range(0, 1));
            a_in      = 8'($urandom);
            b_in      = 8'($urandom);
            opcode_in = 4'($urandom);
         end
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
         pending = in_valid && !acc;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 10) begin tick(); cyc++; end
      chk("rand_drained", exp_q.size(), 0);

      // Reset with both stages full.
      out_ready = 1'b0; in_valid = 1'b1; a_in = 8'h11; b_in = 8'h22; opcode_in = 4'd1;
      cyc = 0;
      while (in_ready && cyc < 10) begin tick(); cyc++; end
      chk("full_in_ready_low", in_ready, 0);
      chk("full_out_valid", out_valid, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0; in_valid = 1'b0;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_result", result_out, 0);
      chk("midrst_flags", flags_out, 0);
      chk("midrst_illegal", illegal_out, 0);
      chk("midrst_in_ready", in_ready, 1);
      out_ready = 1'b1;
      tick();
      tick();
      chk("midrst_no_ghost", out_valid, 0);

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
